// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int N_REQ = 4;
  localparam int CNT_W = 4;

  // Index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter4_if.sv
// Handshake/data bundle between the four requesters and the arbiter.
// Latency: n/a (wires only).
// Backpressure: none; requesters hold req until they see their gnt.
// Signals: req[3:0] requests, d[0:3] per-requester data bit,
//          gnt[3:0] one-hot grant, sel[1:0] owner index, busy, y muxed bit.
interface rr_mux_arbiter4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [0:N_REQ-1] d;
  logic [N_REQ-1:0] gnt;
  logic [1:0]       sel;
  logic             busy;
  logic             y;

  // Requester side drives req/d and observes the grant.
  modport master (output req, output d, input gnt, input sel, input busy, input y);
  // Arbiter side.
  modport slave  (input req, input d, output gnt, output sel, output busy, output y);

endinterface

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first requester at or after ptr (mod 4).
// Latency: combinational.
// Backpressure: n/a.
// Ports: req[3:0], ptr[1:0] in; found, idx[1:0] out.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic             found,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  // Scan from the farthest offset down to ptr itself so the closest
  // requester (lowest offset) is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter with bounded hold driving a 4:1 one-bit mux.
// Latency: 1 clock request-to-grant and handover; y is combinational from d.
// Backpressure: requesters hold req until granted; owner is preempted after HOLD_MAX cycles.
// Ports: clk, rst (async, active high), bus (slave modport of rr_mux_arbiter4_if).
module rr_mux_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 4  // 1..15
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux_arbiter4_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

  arb_state_t       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;

  logic [1:0]       pick_ptr;
  logic [1:0]       pick_idx;
  logic             pick_found;

  // While granted the only pick that matters is the one on release, which
  // uses the pointer just past the owner; in IDLE the stored pointer is used.
  assign pick_ptr = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (bus.req[sel_q] && (cnt_q < HOLD_C)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ptr_d = pick_ptr;
          if (pick_found) begin
            // Direct handover, possibly back to the same owner.
            gnt_d = onehot(pick_idx);
            sel_d = pick_idx;
            cnt_d = CNT_W'(1);
          end else begin
            // sel keeps the last owner.
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.y    = busy_q & bus.d[sel_q];

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Self-checking bench for rr_mux_arbiter4: directed vector table plus
// hand sequences for reset mid-grant, zero-latency y and HOLD_MAX 2 / 1.
module tb_rr_mux_arbiter4;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_arbiter4_if a_if ();
  rr_mux_arbiter4_if b_if ();
  rr_mux_arbiter4_if c_if ();

  rr_mux_arbiter4 #(.HOLD_MAX(4)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  rr_mux_arbiter4 #(.HOLD_MAX(2)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  rr_mux_arbiter4 #(.HOLD_MAX(1)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [0:3] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [0:3] dd, input logic [3:0] g,
                     input logic [1:0] s, input logic b, input logic yy);
    vec_t v;
    v.req = r; v.d = dd; v.gnt = g; v.sel = s; v.busy = b; v.y = yy;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0] o;
    logic [0:3] dpat;

    // ---- vector table: inputs applied, then outputs after the next edge ----
    for (int i = 0; i < 5; i++) add(4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    // All requesting, hold 4: owners 0,1,2,3 for 4 cycles each, then 0 again.
    dpat = 4'b1010;
    for (int k = 0; k < 17; k++) begin
      o = 2'((k / 4) % 4);
      add(4'b1111, dpat, onehot(o), o, 1'b1, dpat[o]);
    end
    add(4'b0010, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1); // owner 0 drops -> 1
    add(4'b1010, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1); // 1 continues
    add(4'b1000, 4'b0110, 4'b1000, 2'd3, 1'b1, 1'b0); // 1 drops -> 3
    add(4'b0001, 4'b0110, 4'b0001, 2'd0, 1'b1, 1'b0); // 3 drops -> 0 (wrap)
    add(4'b0100, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b1); // 0 drops -> 2
    add(4'b0000, 4'b0110, 4'b0000, 2'd2, 1'b0, 1'b0); // 2 drops, idle, sel holds
    add(4'b0000, 4'b0110, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(4'b1001, 4'b0111, 4'b1000, 2'd3, 1'b1, 1'b1); // ptr=3 -> 3 wins
    add(4'b1001, 4'b0110, 4'b1000, 2'd3, 1'b1, 1'b0); // y follows d
    add(4'b0001, 4'b0110, 4'b0001, 2'd0, 1'b1, 1'b0); // 3 drops -> 0
    add(4'b0010, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1); // 0 drops -> 1, ptr=1

    // ---- reset ----
    rst = 1'b1;
    a_if.req = 4'b0000; a_if.d = 4'b1111;
    b_if.req = 4'b0000; b_if.d = 4'b0000;
    c_if.req = 4'b0000; c_if.d = 4'b0000;
    #1;
    chk("reset_gnt",  32'(a_if.gnt),  32'h0);
    chk("reset_sel",  32'(a_if.sel),  32'h0);
    chk("reset_busy", 32'(a_if.busy), 32'h0);
    chk("reset_y",    32'(a_if.y),    32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      a_if.req = vecs[i].req;
      a_if.d   = vecs[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_gnt", i),  32'(a_if.gnt),  32'(vecs[i].gnt));
      chk($sformatf("vec%0d_sel", i),  32'(a_if.sel),  32'(vecs[i].sel));
      chk($sformatf("vec%0d_busy", i), 32'(a_if.busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_y", i),    32'(a_if.y),    32'(vecs[i].y));
    end

    // ---- y tracks d within the cycle (owner 1) ----
    a_if.d = 4'b1011;
    #1 chk("y_comb_lo", 32'(a_if.y), 32'h0);
    a_if.d = 4'b0100;
    #1 chk("y_comb_hi", 32'(a_if.y), 32'h1);

    // ---- reset mid-grant (gnt=0010, ptr=1), clears before next edge ----
    rst = 1'b1;
    #1;
    chk("midrst_gnt",  32'(a_if.gnt),  32'h0);
    chk("midrst_sel",  32'(a_if.sel),  32'h0);
    chk("midrst_busy", 32'(a_if.busy), 32'h0);
    chk("midrst_y",    32'(a_if.y),    32'h0);
    a_if.req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_gnt",  32'(a_if.gnt),  32'h1);
    chk("postrst_sel",  32'(a_if.sel),  32'h0);
    chk("postrst_busy", 32'(a_if.busy), 32'h1);

    // ---- HOLD_MAX=2 lone requester, HOLD_MAX=1 rotation ----
    rst = 1'b1;
    b_if.req = 4'b0100; b_if.d = 4'b0010;
    c_if.req = 4'b0101; c_if.d = 4'b1000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("h2_gnt%0d", i), 32'(b_if.gnt), 32'h4);
      chk($sformatf("h2_sel%0d", i), 32'(b_if.sel), 32'h2);
      chk($sformatf("h2_y%0d", i),   32'(b_if.y),   32'h1);
      chk($sformatf("h2_cnt%0d", i), 32'(u_b.cnt_q), 32'((i % 2) + 1));
      chk($sformatf("h1_gnt%0d", i), 32'(c_if.gnt), (i % 2 == 1) ? 32'h4 : 32'h1);
      chk($sformatf("h1_sel%0d", i), 32'(c_if.sel), (i % 2 == 1) ? 32'h2 : 32'h0);
      chk($sformatf("h1_y%0d", i),   32'(c_if.y),   (i % 2 == 1) ? 32'h0 : 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
